// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared encodings for the cpu_ctrl instruction decoder and FSM.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_GET_A  = 3'd2;
    localparam logic [2:0] S_GET_B  = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_WR_REG = 3'd5;
    localparam logic [2:0] S_WR_IMM = 3'd6;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] NSEL_RN = 2'd0;
    localparam logic [1:0] NSEL_RD = 2'd1;
    localparam logic [1:0] NSEL_RM = 2'd2;

    typedef enum logic [1:0] {
        IC_UNDEF,
        IC_MOV_IMM,
        IC_MOV_REG,
        IC_ALU
    } instr_class_t;

    function automatic instr_class_t classify(input logic [2:0] opcode, input logic [1:0] op);
        instr_class_t c;
        c = IC_UNDEF;
        if (opcode == OPC_MOV && op == OP_MOV_IMM)
            c = IC_MOV_IMM;
        else if (opcode == OPC_MOV && op == OP_MOV_REG)
            c = IC_MOV_REG;
        else if (opcode == OPC_ALU)
            c = IC_ALU;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_if
// Purpose  : Instruction input handshake and datapath control bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_ctrl_if;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        write;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    modport master (
        output s, load, in,
        input  w, readnum, writenum, vsel, loada, loadb, loadc, loads, write,
               asel, bsel, shift, ALUop, sximm8, sximm5
    );

    modport slave (
        input  s, load, in,
        output w, readnum, writenum, vsel, loada, loadb, loadc, loads, write,
               asel, bsel, shift, ALUop, sximm8, sximm5
    );
endinterface
`default_nettype wire

// File: rtl/cpu_ctrl_instr_dec.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_instr_dec
// Purpose  : Combinational IR field extraction, register-index mux, immediates.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ctrl_instr_dec
    import cpu_ctrl_pkg::*;
(
    input  wire logic [15:0] i_ir,
    input  wire logic [1:0]  i_nsel,
    output logic      [2:0]  o_readnum,
    output logic      [2:0]  o_writenum,
    output logic      [1:0]  o_shift,
    output logic      [1:0]  o_alu_field,
    output logic      [15:0] o_sximm8,
    output logic      [15:0] o_sximm5,
    output logic      [2:0]  o_opcode,
    output logic      [1:0]  o_op
);

    logic [2:0] w_regnum;

    always_comb begin
        w_regnum = i_ir[10:8];
        case (i_nsel)
            NSEL_RD: w_regnum = i_ir[7:5];
            NSEL_RM: w_regnum = i_ir[2:0];
            default: w_regnum = i_ir[10:8];
        endcase
    end

    assign o_readnum   = w_regnum;
    assign o_writenum  = w_regnum;
    assign o_shift     = i_ir[4:3];
    assign o_alu_field = i_ir[12:11];
    assign o_opcode    = i_ir[15:13];
    assign o_op        = i_ir[12:11];
    assign o_sximm8    = {{8{i_ir[7]}}, i_ir[7:0]};
    assign o_sximm5    = {{11{i_ir[4]}}, i_ir[4:0]};

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl
// Purpose  : Instruction register and multi-cycle control FSM for the datapath.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ctrl
    import cpu_ctrl_pkg::*;
(
    input wire logic   clk,
    input wire logic   reset,
    cpu_ctrl_if.slave  bus
);

    logic [15:0]  r_ir;
    logic [2:0]   r_state;
    logic [2:0]   w_next;
    logic [1:0]   w_nsel;
    logic [2:0]   w_opcode;
    logic [1:0]   w_op;
    logic [1:0]   w_alu_field;
    logic         w_is_cmp;
    instr_class_t w_class;

    cpu_ctrl_instr_dec u_dec (
        .i_ir        (r_ir),
        .i_nsel      (w_nsel),
        .o_readnum   (bus.readnum),
        .o_writenum  (bus.writenum),
        .o_shift     (bus.shift),
        .o_alu_field (w_alu_field),
        .o_sximm8    (bus.sximm8),
        .o_sximm5    (bus.sximm5),
        .o_opcode    (w_opcode),
        .o_op        (w_op)
    );

    assign w_class  = classify(w_opcode, w_op);
    assign w_is_cmp = (w_class == IC_ALU) && (w_op == OP_CMP);

    // IR only accepts a new word while idle, so a busy-time load cannot corrupt the running instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
        end else begin
            if (r_state == S_WAIT && bus.load)
                r_ir <= bus.in;
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_nsel    = NSEL_RN;
        bus.w     = 1'b0;
        bus.vsel  = VSEL_C;
        bus.loada = 1'b0;
        bus.loadb = 1'b0;
        bus.loadc = 1'b0;
        bus.loads = 1'b0;
        bus.write = 1'b0;
        bus.asel  = 1'b0;
        bus.bsel  = 1'b0;
        bus.ALUop = 2'b00;
        case (r_state)
            S_WAIT: begin
                bus.w = 1'b1;
                if (bus.s)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_class)
                    IC_MOV_IMM: w_next = S_WR_IMM;
                    IC_MOV_REG: w_next = S_GET_B;
                    IC_ALU: begin
                        case (w_op)
                            OP_ADD, OP_CMP, OP_AND: w_next = S_GET_A;
                            default:                w_next = S_GET_B;
                        endcase
                    end
                    default:    w_next = S_WAIT;
                endcase
            end
            S_GET_A: begin
                bus.loada = 1'b1;
                w_next    = S_GET_B;
            end
            S_GET_B: begin
                w_nsel    = NSEL_RM;
                bus.loadb = 1'b1;
                w_next    = S_EXEC;
            end
            S_EXEC: begin
                // MOV reg passes B through the adder with A forced to zero
                if (w_class == IC_MOV_REG) begin
                    bus.asel  = 1'b1;
                    bus.ALUop = 2'b00;
                end else begin
                    bus.ALUop = w_alu_field;
                end
                bus.loadc = ~w_is_cmp;
                bus.loads = w_is_cmp;
                w_next    = w_is_cmp ? S_WAIT : S_WR_REG;
            end
            S_WR_REG: begin
                w_nsel    = NSEL_RD;
                bus.vsel  = VSEL_C;
                bus.write = 1'b1;
                w_next    = S_WAIT;
            end
            S_WR_IMM: begin
                bus.vsel  = VSEL_IMM8;
                bus.write = 1'b1;
                w_next    = S_WAIT;
            end
            default: w_next = S_WAIT;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ctrl
// Purpose  : Directed vector bench for cpu_ctrl instruction sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl;

    typedef struct packed {
        logic        w;
        logic [2:0]  rn;
        logic [2:0]  wn;
        logic [1:0]  vsel;
        logic [6:0]  strb;   // {loada, loadb, loadc, loads, write, asel, bsel}
        logic [1:0]  alu;
        logic [1:0]  shift;
        logic [15:0] imm8;
        logic [15:0] imm5;
    } obs_t;

    typedef struct {
        logic        s;
        logic        load;
        logic [15:0] in;
        obs_t        exp;
    } vec_t;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LA   = 7'b1000000;
    localparam logic [6:0] LB   = 7'b0100000;
    localparam logic [6:0] LC   = 7'b0010000;
    localparam logic [6:0] LS   = 7'b0001000;
    localparam logic [6:0] WR   = 7'b0000100;
    localparam logic [6:0] AS   = 7'b0000010;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;
    obs_t act;
    vec_t vecs[$];

    cpu_ctrl_if bus ();

    cpu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act = {bus.w, bus.readnum, bus.writenum, bus.vsel,
                  {bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write, bus.asel, bus.bsel},
                  bus.ALUop, bus.shift, bus.sximm8, bus.sximm5};

    function automatic obs_t mk(input logic w, input logic [2:0] rn, input logic [1:0] vsel,
                                input logic [6:0] strb, input logic [1:0] alu, input logic [1:0] sh,
                                input logic [15:0] imm8, input logic [15:0] imm5);
        obs_t o;
        o.w = w; o.rn = rn; o.wn = rn; o.vsel = vsel; o.strb = strb;
        o.alu = alu; o.shift = sh; o.imm8 = imm8; o.imm5 = imm5;
        return o;
    endfunction

    task automatic add(input logic s, input logic load, input logic [15:0] in, input obs_t e);
        vec_t v;
        v.s = s; v.load = load; v.in = in; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input obs_t e);
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got w=%0d rn=%0d wn=%0d vsel=%0d strb=%b alu=%0d sh=%0d imm8=%h imm5=%h, expected w=%0d rn=%0d wn=%0d vsel=%0d strb=%b alu=%0d sh=%0d imm8=%h imm5=%h",
                     name, act.w, act.rn, act.wn, act.vsel, act.strb, act.alu, act.shift, act.imm8, act.imm5,
                     e.w, e.rn, e.wn, e.vsel, e.strb, e.alu, e.shift, e.imm8, e.imm5);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_count(input string name, input logic [15:0] instr, input int exp_cnt);
        int cnt = 0;
        bus.in = instr; bus.load = 1'b1; bus.s = 1'b1;
        step();
        bus.load = 1'b0; bus.s = 1'b0;
        while (bus.w == 1'b0 && cnt < 20) begin
            cnt++;
            step();
        end
        n_vec++;
        if (cnt != exp_cnt) begin
            n_bad++;
            $display("FAIL %s: w-low cycles got %0d expected %0d", name, cnt, exp_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_bad = 0;
        bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0000;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2 check("reset_state", mk(1, 0, 0, NONE, 0, 0, 16'h0000, 16'h0000));
        step(); step();
        @(negedge clk) reset = 1'b0;
        step();

        // MOV R1,#-2 with load and s in the same WAIT cycle
        add(1, 1, 16'hD1FE, mk(0, 1, 0, NONE, 0, 3, 16'hFFFE, 16'hFFFE));
        add(0, 0, 16'h0000, mk(0, 1, 2, WR,   0, 3, 16'hFFFE, 16'hFFFE));
        add(0, 0, 16'h0000, mk(1, 1, 0, NONE, 0, 3, 16'hFFFE, 16'hFFFE));
        // ADD R2,R1,R0,LSL#1
        add(0, 1, 16'hA148, mk(1, 1, 0, NONE, 0, 1, 16'h0048, 16'h0008));
        add(1, 0, 16'h0000, mk(0, 1, 0, NONE, 0, 1, 16'h0048, 16'h0008));
        add(0, 0, 16'h0000, mk(0, 1, 0, LA,   0, 1, 16'h0048, 16'h0008));
        add(0, 0, 16'h0000, mk(0, 0, 0, LB,   0, 1, 16'h0048, 16'h0008));
        add(0, 0, 16'h0000, mk(0, 1, 0, LC,   0, 1, 16'h0048, 16'h0008));
        add(0, 0, 16'h0000, mk(0, 2, 0, WR,   0, 1, 16'h0048, 16'h0008));
        add(0, 0, 16'h0000, mk(1, 1, 0, NONE, 0, 1, 16'h0048, 16'h0008));
        // ADD again with load/s held high while busy: must be ignored
        add(1, 0, 16'h0000, mk(0, 1, 0, NONE, 0, 1, 16'h0048, 16'h0008));
        add(1, 1, 16'hD007, mk(0, 1, 0, LA,   0, 1, 16'h0048, 16'h0008));
        add(1, 1, 16'hD007, mk(0, 0, 0, LB,   0, 1, 16'h0048, 16'h0008));
        add(1, 1, 16'hD007, mk(0, 1, 0, LC,   0, 1, 16'h0048, 16'h0008));
        add(1, 1, 16'hD007, mk(0, 2, 0, WR,   0, 1, 16'h0048, 16'h0008));
        add(1, 1, 16'hD007, mk(1, 1, 0, NONE, 0, 1, 16'h0048, 16'h0008));
        add(0, 0, 16'h0000, mk(1, 1, 0, NONE, 0, 1, 16'h0048, 16'h0008));
        // CMP R0,R1
        add(1, 1, 16'hA801, mk(0, 0, 0, NONE, 0, 0, 16'h0001, 16'h0001));
        add(0, 0, 16'h0000, mk(0, 0, 0, LA,   0, 0, 16'h0001, 16'h0001));
        add(0, 0, 16'h0000, mk(0, 1, 0, LB,   0, 0, 16'h0001, 16'h0001));
        add(0, 0, 16'h0000, mk(0, 0, 0, LS,   1, 0, 16'h0001, 16'h0001));
        add(0, 0, 16'h0000, mk(1, 0, 0, NONE, 0, 0, 16'h0001, 16'h0001));
        // MVN R3,R0
        add(1, 1, 16'hB860, mk(0, 0, 0, NONE, 0, 0, 16'h0060, 16'h0000));
        add(0, 0, 16'h0000, mk(0, 0, 0, LB,   0, 0, 16'h0060, 16'h0000));
        add(0, 0, 16'h0000, mk(0, 0, 0, LC,   3, 0, 16'h0060, 16'h0000));
        add(0, 0, 16'h0000, mk(0, 3, 0, WR,   0, 0, 16'h0060, 16'h0000));
        add(0, 0, 16'h0000, mk(1, 0, 0, NONE, 0, 0, 16'h0060, 16'h0000));
        // MOV R4,R5,LSR#1
        add(1, 1, 16'hC095, mk(0, 0, 0, NONE,    0, 2, 16'hFF95, 16'hFFF5));
        add(0, 0, 16'h0000, mk(0, 5, 0, LB,      0, 2, 16'hFF95, 16'hFFF5));
        add(0, 0, 16'h0000, mk(0, 0, 0, LC | AS, 0, 2, 16'hFF95, 16'hFFF5));
        add(0, 0, 16'h0000, mk(0, 4, 0, WR,      0, 2, 16'hFF95, 16'hFFF5));
        add(0, 0, 16'h0000, mk(1, 0, 0, NONE,    0, 2, 16'hFF95, 16'hFFF5));
        // AND R7,R6,R5
        add(1, 1, 16'hB6E5, mk(0, 6, 0, NONE, 0, 0, 16'hFFE5, 16'h0005));
        add(0, 0, 16'h0000, mk(0, 6, 0, LA,   0, 0, 16'hFFE5, 16'h0005));
        add(0, 0, 16'h0000, mk(0, 5, 0, LB,   0, 0, 16'hFFE5, 16'h0005));
        add(0, 0, 16'h0000, mk(0, 6, 0, LC,   2, 0, 16'hFFE5, 16'h0005));
        add(0, 0, 16'h0000, mk(0, 7, 0, WR,   0, 0, 16'hFFE5, 16'h0005));
        add(0, 0, 16'h0000, mk(1, 6, 0, NONE, 0, 0, 16'hFFE5, 16'h0005));
        // Undefined opcode: one busy cycle, no strobes
        add(1, 1, 16'hE000, mk(0, 0, 0, NONE, 0, 0, 16'h0000, 16'h0000));
        add(0, 0, 16'h0000, mk(1, 0, 0, NONE, 0, 0, 16'h0000, 16'h0000));
        add(0, 0, 16'h0000, mk(1, 0, 0, NONE, 0, 0, 16'h0000, 16'h0000));

        for (int i = 0; i < vecs.size(); i++) begin
            bus.s = vecs[i].s; bus.load = vecs[i].load; bus.in = vecs[i].in;
            step();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
        bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0000;

        // Reset asserted during GET_B of ADD aborts immediately
        bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
        step();
        bus.load = 1'b0; bus.s = 1'b0;
        step(); step();
        check("mid_rst_getb", mk(0, 0, 0, LB, 0, 1, 16'h0048, 16'h0008));
        #2 reset = 1'b1;
        #1 check("mid_rst_async", mk(1, 0, 0, NONE, 0, 0, 16'h0000, 16'h0000));
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_rst_idle%0d", i), mk(1, 0, 0, NONE, 0, 0, 16'h0000, 16'h0000));
        end

        run_count("cnt_mov_imm", 16'hD1FE, 2);
        run_count("cnt_add",     16'hA148, 5);
        run_count("cnt_cmp",     16'hA801, 4);
        run_count("cnt_mvn",     16'hB860, 4);
        run_count("cnt_mov_reg", 16'hC095, 4);
        run_count("cnt_and",     16'hB6E5, 5);
        run_count("cnt_undef",   16'hE000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
